// File: rtl/reg2uart.sv
// APB slave that turns each register access into a framed byte stream on an AXIS
// link to a UART, and collects the read-response frame from the return stream.
`timescale 1ns/1ps
module reg2uart #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  input  logic [3:0]  dst_fpga,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [8:0]  m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [8:0]  s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        busy,
  output logic        timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, HDR, ADDR0, ADDR1, WD0, WD1, WD2, WD3,
    WAIT_HDR, RD0, RD1, RD2, RD3, DONE
  } state_t;

  state_t           state, state_nx;
  logic             is_wr, wr_nx;
  logic [15:0]      addr, addr_nx;
  logic [31:0]      wdata, wdata_nx;
  logic [3:0]       dst, dst_nx;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [23:0]      rd_buf;
  logic             start, m_hs, in_rx, expired, hdr_ok, fire, fail;
  logic [7:0]       tx_byte_nx;
  logic             tx_valid_nx, tx_last_nx;
  logic             unused;

  assign unused        = &{1'b0, pstrb, s_axis_tlast, s_axis_tdata[8]};
  assign s_axis_tready = 1'b1;
  assign m_axis_tuser  = 1'b0;
  assign pready        = (state == DONE);
  assign pslverr       = (state == DONE) && err;

  assign start   = (state == IDLE) && psel && penable;
  assign m_hs    = m_axis_tvalid && m_axis_tready;
  assign in_rx   = state inside {WAIT_HDR, RD0, RD1, RD2, RD3};
  assign expired = (cnt >= CNT_LAST);
  assign hdr_ok  = (s_axis_tdata[7:4] == dst) && (s_axis_tdata[3:1] == 3'd3) && !s_axis_tdata[0];

  // Transfer fields as they will be after this edge, so the tx byte can be registered.
  assign wr_nx    = start ? pwrite   : is_wr;
  assign addr_nx  = start ? paddr    : addr;
  assign wdata_nx = start ? pwdata   : wdata;
  assign dst_nx   = start ? dst_fpga : dst;

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    fail     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nx = HDR;
      HDR:   if (m_hs) state_nx = ADDR0;
      ADDR0: if (m_hs) state_nx = ADDR1;
      ADDR1: if (m_hs) state_nx = is_wr ? WD0 : WAIT_HDR;
      WD0:   if (m_hs) state_nx = WD1;
      WD1:   if (m_hs) state_nx = WD2;
      WD2:   if (m_hs) state_nx = WD3;
      WD3:   if (m_hs) state_nx = DONE;
      // An arriving byte always takes priority over an expiring counter.
      WAIT_HDR: begin
        if (s_axis_tvalid) begin
          if (hdr_ok) state_nx = RD0;
        end else if (expired) begin
          state_nx = DONE;
          fire     = 1'b1;
        end
      end
      RD0, RD1, RD2, RD3: begin
        if (s_axis_tvalid) begin
          if (s_axis_tuser) begin
            state_nx = DONE;
            fail     = 1'b1;
          end else begin
            unique case (state)
              RD0:     state_nx = RD1;
              RD1:     state_nx = RD2;
              RD2:     state_nx = RD3;
              default: state_nx = DONE;
            endcase
          end
        end else if (expired) begin
          state_nx = DONE;
          fire     = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_byte_nx  = 8'h00;
    tx_valid_nx = 1'b1;
    tx_last_nx  = 1'b0;
    unique case (state_nx)
      HDR:   tx_byte_nx = {dst_nx, (wr_nx ? 3'd1 : 3'd2), 1'b0};
      ADDR0: tx_byte_nx = addr_nx[15:8];
      ADDR1: begin
        tx_byte_nx = addr_nx[7:0];
        tx_last_nx = !wr_nx;
      end
      WD0:   tx_byte_nx = wdata_nx[7:0];
      WD1:   tx_byte_nx = wdata_nx[15:8];
      WD2:   tx_byte_nx = wdata_nx[23:16];
      WD3: begin
        tx_byte_nx = wdata_nx[31:24];
        tx_last_nx = 1'b1;
      end
      default: tx_valid_nx = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      timeout       <= 1'b0;
      prdata        <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      is_wr         <= 1'b0;
      addr          <= '0;
      wdata         <= '0;
      dst           <= '0;
      rd_buf        <= '0;
    end else begin
      state         <= state_nx;
      busy          <= (state_nx != IDLE);
      m_axis_tvalid <= tx_valid_nx;
      m_axis_tdata  <= {1'b0, tx_byte_nx};
      m_axis_tlast  <= tx_last_nx;
      is_wr         <= wr_nx;
      addr          <= addr_nx;
      wdata         <= wdata_nx;
      dst           <= dst_nx;
      if (start) begin
        timeout <= 1'b0;
        err     <= 1'b0;
      end
      // Saturates one short of the limit; expiry is then re-evaluated every idle cycle.
      if (state_nx == WAIT_HDR && state != WAIT_HDR) cnt <= '0;
      else if (in_rx && !expired)                     cnt <= cnt + CNT_W'(1);
      if (s_axis_tvalid) begin
        unique case (state)
          RD0:     rd_buf[7:0]   <= s_axis_tdata[7:0];
          RD1:     rd_buf[15:8]  <= s_axis_tdata[7:0];
          RD2:     rd_buf[23:16] <= s_axis_tdata[7:0];
          RD3:     if (!s_axis_tuser) prdata <= {s_axis_tdata[7:0], rd_buf};
          default: ;
        endcase
      end
      if (fire || fail) begin
        prdata <= '0;
        err    <= 1'b1;
      end
      if (fire) timeout <= 1'b1;
    end
  end
endmodule
